// File: rtl/mem_writeback.sv
// mem_writeback: retires execute results into the register file,
// runs data-memory stores/loads and issues fetch redirects.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_*      execute-stage result bundle
//   stall               1 while busy (state != IDLE)
//   rf_we/waddr/wdata   register-file write port
//   mem_req/we/addr/    data-memory request, held until mem_ack
//   mem_wdata, mem_rdata, mem_ack
//   br_taken, br_target fetch redirect
//   mem_err             sticky timeout flag (MEMWB_TIMEOUT_EN only)
//
// Build option: define MEMWB_TIMEOUT_EN to abandon a memory access
// after 16 unacknowledged MEM_WAIT cycles and raise mem_err.
module mem_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_opcode,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rd,
  input  logic [31:0] in_rd_mem,
  input  logic [31:0] in_mem_result,
  input  logic [31:0] in_mem_out,
  input  logic [31:0] in_branch,
  input  logic        in_wrenable,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        br_taken,
  output logic [31:0] br_target
`ifdef MEMWB_TIMEOUT_EN
  ,
  output logic        mem_err
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    LOAD_WB  = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_target_q, br_target_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [4:0]  ld_dst_q, ld_dst_d;

`ifdef MEMWB_TIMEOUT_EN
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  logic        is_alu;
  logic        is_cp;
  logic        is_b;
  logic        is_beg;
  logic        is_gp;

  // Only the low five bits of in_rd name a register.
  logic        unused_rd;
  assign unused_rd = ^in_rd[31:5];

  assign is_alu = ((in_opcode >= 5'd1)
                && (in_opcode <= 5'd5))
               || (in_opcode == 5'd9);
  assign is_cp  = (in_opcode == 5'd6);
  assign is_b   = (in_opcode == 5'd7);
  assign is_beg = (in_opcode == 5'd8);
  assign is_gp  = (in_opcode == 5'd10);

  assign stall     = (state_q != IDLE);
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef MEMWB_TIMEOUT_EN
  assign mem_err   = err_q;
`endif

  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = 5'd0;
    rf_wdata_d  = 32'd0;
    br_taken_d  = 1'b0;
    br_target_d = 32'd0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_dst_d    = ld_dst_q;
`ifdef MEMWB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            is_alu: begin
              if (in_wrenable) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = in_rd[4:0];
                rf_wdata_d = in_alu_result;
              end
            end
            is_cp: begin
              state_d     = MEM_WAIT;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = in_rd_mem;
              mem_wdata_d = in_mem_result;
`ifdef MEMWB_TIMEOUT_EN
              cnt_d       = 4'd0;
`endif
            end
            is_gp: begin
              state_d     = MEM_WAIT;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_addr_d  = in_mem_out;
              mem_wdata_d = 32'd0;
              ld_dst_d    = in_rd_mem[4:0];
`ifdef MEMWB_TIMEOUT_EN
              cnt_d       = 4'd0;
`endif
            end
            is_b: begin
              br_taken_d  = 1'b1;
              br_target_d = in_branch;
            end
            is_beg: begin
              if (in_branch != 32'd0) begin
                br_taken_d  = 1'b1;
                br_target_d = in_branch;
              end
            end
            default: begin
            end
          endcase
        end
      end

      // mem_req is always high here, so ack is
      // only ever seen against a live request.
      MEM_WAIT: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          ld_dst_d    = 5'd0;
`ifdef MEMWB_TIMEOUT_EN
          cnt_d       = 4'd0;
`endif
          if (mem_we_q) begin
            state_d = IDLE;
          end else begin
            state_d    = LOAD_WB;
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_dst_q;
            rf_wdata_d = mem_rdata;
          end
        end
`ifdef MEMWB_TIMEOUT_EN
        // 16th unacknowledged cycle: give up.
        else if (cnt_q == 4'hF) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          ld_dst_d    = 5'd0;
          cnt_d       = 4'd0;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end

      // rf write is already registered on the
      // ack edge; this state just covers it.
      LOAD_WB: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
      br_taken_q  <= 1'b0;
      br_target_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      ld_dst_q    <= 5'd0;
`ifdef MEMWB_TIMEOUT_EN
      cnt_q       <= 4'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_dst_q    <= ld_dst_d;
`ifdef MEMWB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// tb_mem_writeback: scoreboard bench for mem_writeback.
// Directed ops push expected events; a negedge monitor pops them.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_opcode;
  logic [31:0] in_alu_result;
  logic [31:0] in_rd;
  logic [31:0] in_rd_mem;
  logic [31:0] in_mem_result;
  logic [31:0] in_mem_out;
  logic [31:0] in_branch;
  logic        in_wrenable;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        br_taken;
  logic [31:0] br_target;
`ifdef MEMWB_TIMEOUT_EN
  logic        mem_err;
`endif

  always #5 clk = ~clk;

  mem_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_opcode     (in_opcode),
    .in_alu_result (in_alu_result),
    .in_rd         (in_rd),
    .in_rd_mem     (in_rd_mem),
    .in_mem_result (in_mem_result),
    .in_mem_out    (in_mem_out),
    .in_branch     (in_branch),
    .in_wrenable   (in_wrenable),
    .stall         (stall),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .br_taken      (br_taken),
    .br_target     (br_target)
`ifdef MEMWB_TIMEOUT_EN
    ,
    .mem_err       (mem_err)
`endif
  );

  localparam logic [1:0] K_RF = 2'd0;
  localparam logic [1:0] K_BR = 2'd1;
  localparam logic [1:0] K_ST = 2'd2;
  localparam logic [1:0] K_LD = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t sb[$];
  int  ntests = 0;
  int  nfail  = 0;
  bit  mon_on = 1'b0;

  task automatic push(input logic [1:0] k,
                      input logic [31:0] a,
                      input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] k,
                         input logic [31:0] a,
                         input logic [31:0] d);
    ev_t e;
    ntests++;
    if (sb.size() == 0) begin
      nfail++;
      $display("FAIL unexpected_event: got kind %0d a=%h d=%h, expected none",
               k, a, d);
    end else begin
      e = sb.pop_front();
      if (e.kind !== k || e.a !== a || e.d !== d) begin
        nfail++;
        $display("FAIL event: got kind %0d a=%h d=%h expected kind %0d a=%h d=%h",
                 k, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  // Monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rf_we && br_taken) begin
        ntests++;
        nfail++;
        $display("FAIL rf_br_overlap: got both 1 expected exclusive");
      end
      if (rf_we)
        pop_cmp(K_RF, {27'd0, rf_waddr}, rf_wdata);
      else
        chk("rf_idle_zero", {27'd0, rf_waddr} | rf_wdata, 32'd0);
      if (br_taken)
        pop_cmp(K_BR, 32'd0, br_target);
      else
        chk("br_idle_zero", br_target, 32'd0);
      if (mem_req && mem_ack)
        pop_cmp(mem_we ? K_ST : K_LD, mem_addr, mem_wdata);
      else if (!mem_req)
        chk("mem_idle_zero",
            {31'd0, mem_we} | mem_addr | mem_wdata, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0]  op,
                       input logic        wr,
                       input logic [31:0] alu,
                       input logic [31:0] rd,
                       input logic [31:0] rdm,
                       input logic [31:0] mres,
                       input logic [31:0] mout,
                       input logic [31:0] br);
    int n;
    n = 0;
    while (stall && n < 50) begin
      tick();
      n++;
    end
    if (stall) begin
      ntests++;
      nfail++;
      $display("FAIL issue_wait: got stall=1 expected 0 within 50 cycles");
    end
    in_opcode     = op;
    in_wrenable   = wr;
    in_alu_result = alu;
    in_rd         = rd;
    in_rd_mem     = rdm;
    in_mem_result = mres;
    in_mem_out    = mout;
    in_branch     = br;
    in_valid      = 1'b1;
    tick();
    in_valid      = 1'b0;
    in_opcode     = 5'd0;
    in_wrenable   = 1'b0;
    in_alu_result = 32'd0;
    in_rd         = 32'd0;
    in_rd_mem     = 32'd0;
    in_mem_result = 32'd0;
    in_mem_out    = 32'd0;
    in_branch     = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_opcode = 5'd0;
    in_alu_result = 32'd0;
    in_rd = 32'd0;
    in_rd_mem = 32'd0;
    in_mem_result = 32'd0;
    in_mem_out = 32'd0;
    in_branch = 32'd0;
    in_wrenable = 1'b0;
    mem_rdata = 32'd0;
    mem_ack = 1'b0;

    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_br", {31'd0, br_taken}, 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;

    // Sum: op 5 writes rd 3.
    push(K_RF, 32'd3, 32'h2A);
    issue(5'd5, 1'b1, 32'h2A, 32'd3, 0, 0, 0, 0);
    chk("sum_rf_we", {31'd0, rf_we}, 32'd1);
    chk("sum_stall", {31'd0, stall}, 32'd0);

    // Back-to-back ALU; op 9 uses only rd[4:0].
    push(K_RF, 32'd5, 32'hCAFE0001);
    push(K_RF, 32'd31, 32'h00000077);
    issue(5'd9, 1'b1, 32'hCAFE0001, 32'hFFFFFFE5, 0, 0, 0, 0);
    issue(5'd1, 1'b1, 32'h77, 32'd31, 0, 0, 0, 0);

    // No-effect ops.
    issue(5'd2, 1'b0, 32'h55, 32'd4, 0, 0, 0, 0);
    issue(5'd0, 1'b1, 32'h66, 32'd4, 0, 0, 0, 0);
    issue(5'd15, 1'b1, 32'h66, 32'd4, 0, 0, 0, 0);
    chk("noeff_stall", {31'd0, stall}, 32'd0);

    // Stray ack with no request.
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_stall", {31'd0, stall}, 32'd0);

    // CP store, ack in the third request cycle.
    push(K_ST, 32'h100, 32'hDEADBEEF);
    issue(5'd6, 1'b0, 0, 0, 32'h100, 32'hDEADBEEF, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      chk("cp_req", {31'd0, mem_req}, 32'd1);
      chk("cp_we", {31'd0, mem_we}, 32'd1);
      chk("cp_addr", mem_addr, 32'h100);
      chk("cp_stall", {31'd0, stall}, 32'd1);
      if (c == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("cp_done_req", {31'd0, mem_req}, 32'd0);
    chk("cp_done_stall", {31'd0, stall}, 32'd0);
    chk("cp_no_rf", {31'd0, rf_we}, 32'd0);

    // GP load, same-cycle ack.
    push(K_LD, 32'h40, 32'd0);
    push(K_RF, 32'd7, 32'h1234);
    mem_rdata = 32'h1234;
    issue(5'd10, 1'b0, 0, 0, 32'd7, 0, 32'h40, 0);
    mem_ack = 1'b1;
    chk("gp_req", {31'd0, mem_req}, 32'd1);
    chk("gp_we", {31'd0, mem_we}, 32'd0);
    chk("gp_addr", mem_addr, 32'h40);
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'hFFFF0000;
    chk("gp_rf_we", {31'd0, rf_we}, 32'd1);
    chk("gp_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("gp_wdata", rf_wdata, 32'h1234);
    chk("gp_wb_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("gp_end_rf_we", {31'd0, rf_we}, 32'd0);
    chk("gp_end_stall", {31'd0, stall}, 32'd0);

    // Branches.
    push(K_BR, 32'd0, 32'h80);
    issue(5'd7, 1'b0, 0, 0, 0, 0, 0, 32'h80);
    chk("b_taken", {31'd0, br_taken}, 32'd1);
    push(K_BR, 32'd0, 32'h20);
    issue(5'd8, 1'b0, 0, 0, 0, 0, 0, 32'h20);
    chk("beg_target", br_target, 32'h20);
    issue(5'd8, 1'b0, 0, 0, 0, 0, 0, 32'h0);
    chk("beg0_taken", {31'd0, br_taken}, 32'd0);
    tick();

    // Reset beats acceptance on the same edge.
    rst = 1'b1;
    in_valid = 1'b1;
    in_opcode = 5'd5;
    in_wrenable = 1'b1;
    in_rd = 32'd9;
    in_alu_result = 32'h99;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    in_opcode = 5'd0;
    in_wrenable = 1'b0;
    in_rd = 32'd0;
    in_alu_result = 32'd0;
    chk("rstpri_rf_we", {31'd0, rf_we}, 32'd0);

    // Reset in MEM_WAIT, late ack ignored.
    issue(5'd10, 1'b0, 0, 0, 32'd4, 0, 32'h80, 0);
    tick();
    chk("rmw_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmw_req", {31'd0, mem_req}, 32'd0);
    chk("rmw_stall0", {31'd0, stall}, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h5555;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("rmw_no_rf", {31'd0, rf_we}, 32'd0);

`ifdef MEMWB_TIMEOUT_EN
    // Unacknowledged load times out after 16 cycles.
    issue(5'd10, 1'b0, 0, 0, 32'd2, 0, 32'h44, 0);
    for (int c = 1; c < 16; c++) tick();
    chk("to_req16", {31'd0, mem_req}, 32'd1);
    chk("to_err_pre", {31'd0, mem_err}, 32'd0);
    tick();
    chk("to_req", {31'd0, mem_req}, 32'd0);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_stall", {31'd0, stall}, 32'd0);
    chk("to_no_rf", {31'd0, rf_we}, 32'd0);
    push(K_RF, 32'd1, 32'h11);
    issue(5'd3, 1'b1, 32'h11, 32'd1, 0, 0, 0, 0);
    chk("to_err_sticky", {31'd0, mem_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_err_clr", {31'd0, mem_err}, 32'd0);
`else
    // Without timeout, MEM_WAIT holds indefinitely.
    push(K_LD, 32'h44, 32'd0);
    push(K_RF, 32'd2, 32'hABCD);
    issue(5'd10, 1'b0, 0, 0, 32'd2, 0, 32'h44, 0);
    for (int c = 1; c < 20; c++) tick();
    chk("wait_req20", {31'd0, mem_req}, 32'd1);
    chk("wait_addr20", mem_addr, 32'h44);
    mem_rdata = 32'hABCD;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wait_rf_we", {31'd0, rf_we}, 32'd1);
    tick();
`endif

    tick();
    tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 The block SHALL have the ports below, clock and reset first, listed as name, direction, width, meaning.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset; synchronous and active-high, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  execute-stage result present this cycle.
REQ-005 in_opcode  input  5  operation code forwarded by execute (0 NOP, 1-5 and 9 ALU write, 6 CP, 7 B, 8 BEG, 10 GP).
REQ-006 in_alu_result, in_rd, in_rd_mem, in_mem_result, in_mem_out, in_branch  input  32 each  execute-stage result fields.
REQ-007 in_wrenable  input  1  register write request for opcodes 1-5 and 9.
REQ-008 stall  output  1  upstream SHALL hold all in_* signals while stall=1; stall=0 is the ready indication.
REQ-009 rf_we  output  1, rf_waddr  output  5, rf_wdata  output  32  register-file write port.
REQ-010 mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32  data-memory request.
REQ-011 mem_rdata  input  32, mem_ack  input  1  data-memory response.
REQ-012 br_taken  output  1, br_target  output  32  fetch redirect.
REQ-013 mem_err  output  1  sticky memory timeout flag; present only when MEMWB_TIMEOUT_EN is defined.

Function
REQ-014 Acceptance SHALL occur on an edge where in_valid=1 and the state is IDLE; stall SHALL equal (state != IDLE), combinationally.
REQ-015 States SHALL be IDLE, MEM_WAIT and LOAD_WB; reset SHALL enter IDLE.
REQ-016 ALU ops (1-5, 9) with in_wrenable=1: the cycle after acceptance, rf_we=1, rf_waddr=in_rd[4:0], rf_wdata=in_alu_result, for exactly one cycle; state SHALL remain IDLE.
REQ-017 ALU ops with in_wrenable=0, opcode 0 and opcodes 11-31: accepted with no output effect.
REQ-018 CP (6): IDLE->MEM_WAIT; mem_req=1, mem_we=1, mem_addr=in_rd_mem, mem_wdata=in_mem_result, starting the cycle after acceptance.
REQ-019 GP (10) is a load: IDLE->MEM_WAIT; mem_req=1, mem_we=0, mem_addr=in_mem_out; the destination is in_rd_mem[4:0].
REQ-020 In MEM_WAIT, mem_req and all request fields SHALL be held stable until a cycle with mem_ack=1; mem_ack in the first request cycle SHALL be honoured.
REQ-021 Store completion: on the mem_ack edge, MEM_WAIT->IDLE and mem_req drops the next cycle.
REQ-022 Load completion: on the mem_ack edge, mem_rdata is captured and the state goes MEM_WAIT->LOAD_WB; in LOAD_WB, rf_we=1 with the captured data for one cycle, then the state goes to IDLE.
REQ-023 mem_ack while mem_req=0 SHALL be ignored.
REQ-024 B (7): the cycle after acceptance, br_taken=1 and br_target=in_branch, for one cycle.
REQ-025 BEG (8): the same as B when in_branch != 0; otherwise there is no effect.
REQ-026 rf_we and br_taken SHALL never be asserted in the same cycle; at most one rf write SHALL occur per accepted op.
REQ-027 While outputs are not asserted, rf_waddr, rf_wdata, mem_addr, mem_wdata and br_target SHALL be 0.

Reset
REQ-028 With rst=1 on an edge, every output SHALL be 0 the following cycle, the state SHALL be IDLE and any captured data SHALL be cleared.
REQ-029 Reset during MEM_WAIT or LOAD_WB SHALL abandon the access: mem_req=0 and no rf write follows, even if mem_ack arrives later.
REQ-030 rst SHALL take priority over acceptance and mem_ack on the same edge.

Configuration
REQ-031 With macro MEMWB_TIMEOUT_EN defined: a 4-bit counter SHALL count MEM_WAIT cycles; if 16 cycles pass without mem_ack, the block SHALL go to IDLE, drop mem_req, perform no rf write and set mem_err=1 until rst.
REQ-032 Without MEMWB_TIMEOUT_EN: the mem_err port and the counter SHALL be absent, and MEM_WAIT SHALL wait indefinitely.

Verification
REQ-033 Sum: accept op 5 with rd=3, alu_result=0x0000002A, wrenable=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x2A; stall stays 0.
REQ-034 CP: accept op 6 with rd_mem=0x100, mem_result=0xDEADBEEF; ack after 3 cycles -> mem_req=1 with mem_we=1 for 3 cycles and stall=1; no rf_we.
REQ-035 GP: accept op 10 with mem_out=0x40, rd_mem=7; mem_rdata=0x1234 with same-cycle ack -> next cycle rf_we=1, rf_waddr=7, rf_wdata=0x1234.
REQ-036 BEG: in_branch=0x20 -> br_taken=1 and br_target=0x20; in_branch=0 -> br_taken stays 0.
REQ-037 Reset in MEM_WAIT, then ack -> mem_req=0 after the edge and no rf_we.
REQ-038 With MEMWB_TIMEOUT_EN defined: a load with no ack -> after 16 cycles, mem_req=0, mem_err=1, stall=0.
